// File: rtl/cache_controller_nway_if.sv
// Signal bundle between the N-way cache controller, the processor port,
// the per-way cache banks and the pipelined main memory.
interface cache_controller_nway_if #(
  parameter int unsigned WAYS           = 2,
  parameter int unsigned WORDS_PER_LINE = 4
);
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE) + 1;

  logic [15:0]      addr_in;
  logic [15:0]      data_in;
  logic             rd_in;
  logic             wr_in;
  logic [WAYS-1:0]  cache_hit;
  logic [WAYS-1:0]  cache_valid;
  logic [WAYS-1:0]  cache_dirty;
  logic [15:0]      addr_out;
  logic [15:0]      data_out;
  logic [WAYS-1:0]  cache_enable;
  logic [OFF_W-1:0] cache_offset;
  logic [OFF_W-1:0] mem_offset;
  logic             comp;
  logic             write;
  logic             tag_src;
  logic             data_src;
  logic             rd_out;
  logic             wr_out;
  logic             done;
  logic             stall;
  logic             hit;
  logic             err;

  modport master (
    input  addr_in, data_in, rd_in, wr_in, cache_hit, cache_valid, cache_dirty,
    output addr_out, data_out, cache_enable, cache_offset, mem_offset, comp, write,
           tag_src, data_src, rd_out, wr_out, done, stall, hit, err
  );

  modport slave (
    output addr_in, data_in, rd_in, wr_in, cache_hit, cache_valid, cache_dirty,
    input  addr_out, data_out, cache_enable, cache_offset, mem_offset, comp, write,
           tag_src, data_src, rd_out, wr_out, done, stall, hit, err
  );
endinterface

// File: rtl/cache_controller_nway.sv
// N-way write-back, write-allocate cache controller with per-set tree pseudo-LRU.
// Hits finish in the request cycle; misses write back a dirty victim, then refill.
module cache_controller_nway #(
  parameter int unsigned WAYS           = 2,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned MEM_LAT        = 2,
  parameter int unsigned INDEX_BITS     = 8
) (
  input logic                     clk,
  input logic                     rst,
  cache_controller_nway_if.master bus
);
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE) + 1;
  localparam int unsigned SETS  = 2 ** INDEX_BITS;
  localparam int unsigned PW    = WAYS - 1;
  localparam int unsigned CNT_W = $clog2(WORDS_PER_LINE + MEM_LAT + 1);

  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] Lat      = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] Words    = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] WbLast   = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] FillLast = CNT_W'(WORDS_PER_LINE + MEM_LAT - 1);
  localparam logic [WAYS-1:0]  OneWay   = WAYS'(1);

  typedef enum logic [2:0] {StIdle, StAlloc, StWb, StFill, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      addr_q;
  logic [15:0]      data_q;
  logic             wr_q;
  logic [WAYS-1:0]  valid_q;
  logic [WAYS-1:0]  dirty_q;
  logic [1:0]       victim_q;
  logic [PW-1:0]    plru_q [SETS];

  // Tree bit 0 is the root (1 = right half); bits 1/2 pick within the left/right pair.
  function automatic logic [1:0] plru_victim(input logic [2:0] t);
    if (WAYS == 2) return {1'b0, t[0]};
    return t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] t, input logic [1:0] w);
    logic [2:0] n;
    n = t;
    if (WAYS == 2) begin
      n[0] = ~w[0];
    end else begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end
    return n;
  endfunction

  logic                  req, conflict, any_hit, alloc_dirty;
  logic [WAYS-1:0]       hit_vec, alloc_oh, victim_oh;
  logic [1:0]            hit_way, alloc_way;
  logic [INDEX_BITS-1:0] idx_in, idx_q;
  logic [CNT_W-1:0]      fill_j;
  logic [OFF_W-1:0]      cnt_off, fill_off;

  assign idx_in    = bus.addr_in[OFF_W+INDEX_BITS-1:OFF_W];
  assign idx_q     = addr_q[OFF_W+INDEX_BITS-1:OFF_W];
  assign req       = bus.rd_in | bus.wr_in;
  assign conflict  = bus.rd_in & bus.wr_in;
  assign hit_vec   = bus.cache_hit & bus.cache_valid;
  assign any_hit   = |hit_vec;
  assign fill_j    = cnt_q - Lat;
  assign cnt_off   = OFF_W'({cnt_q, 1'b0});
  assign fill_off  = OFF_W'({fill_j, 1'b0});
  assign victim_oh = OneWay << victim_q;

  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = 2'(i);
    end
    // Prefer the lowest invalid way; fall back to the tree victim only when the set is full.
    alloc_way = plru_victim(3'(plru_q[idx_q]));
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_way = 2'(i);
    end
    alloc_oh    = OneWay << alloc_way;
    alloc_dirty = |(valid_q & dirty_q & alloc_oh);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && !conflict) begin
            if (any_hit) begin
              plru_q[idx_in] <= PW'(plru_touch(3'(plru_q[idx_in]), hit_way));
            end else begin
              addr_q  <= bus.addr_in;
              data_q  <= bus.data_in;
              wr_q    <= bus.wr_in;
              valid_q <= bus.cache_valid;
              dirty_q <= bus.cache_dirty;
              state_q <= StAlloc;
            end
          end
        end
        StAlloc: begin
          victim_q <= alloc_way;
          cnt_q    <= '0;
          state_q  <= alloc_dirty ? StWb : StFill;
        end
        StWb: begin
          if (cnt_q == WbLast) begin
            cnt_q   <= '0;
            state_q <= StFill;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StFill: begin
          if (cnt_q == FillLast) begin
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StDone: begin
          plru_q[idx_q] <= PW'(plru_touch(3'(plru_q[idx_q]), victim_q));
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.addr_out     = addr_q;
    bus.data_out     = data_q;
    bus.cache_enable = '0;
    bus.cache_offset = addr_q[OFF_W-1:0];
    bus.mem_offset   = '0;
    bus.comp         = 1'b0;
    bus.write        = 1'b0;
    bus.tag_src      = 1'b0;
    bus.data_src     = 1'b0;
    bus.rd_out       = 1'b0;
    bus.wr_out       = 1'b0;
    bus.done         = 1'b0;
    bus.stall        = 1'b0;
    bus.hit          = 1'b0;
    bus.err          = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.addr_out     = bus.addr_in;
        bus.data_out     = bus.data_in;
        bus.cache_offset = bus.addr_in[OFF_W-1:0];
        if (conflict) begin
          bus.err  = 1'b1;
          bus.done = 1'b1;
        end else if (req) begin
          bus.comp         = 1'b1;
          bus.write        = bus.wr_in;
          bus.cache_enable = '1;
          bus.done         = any_hit;
          bus.hit          = any_hit;
          bus.stall        = ~any_hit;
        end
      end
      StAlloc: begin
        bus.cache_enable = alloc_oh;
        bus.stall        = 1'b1;
      end
      StWb: begin
        bus.cache_enable = victim_oh;
        bus.tag_src      = 1'b1;
        bus.wr_out       = 1'b1;
        bus.cache_offset = cnt_off;
        bus.mem_offset   = cnt_off;
        bus.stall        = 1'b1;
      end
      StFill: begin
        bus.cache_enable = victim_oh;
        bus.stall        = 1'b1;
        if (cnt_q < Words) begin
          bus.rd_out     = 1'b1;
          bus.mem_offset = cnt_off;
        end
        if (cnt_q >= Lat) begin
          bus.write        = 1'b1;
          bus.data_src     = 1'b1;
          bus.cache_offset = fill_off;
        end
      end
      StDone: begin
        bus.cache_enable = victim_oh;
        bus.comp         = 1'b1;
        bus.write        = wr_q;
        bus.done         = 1'b1;
      end
      default: bus.err = 1'b1;
    endcase
    // Outputs read as zero for as long as reset is held.
    if (!rst) begin
      bus.addr_out     = '0;
      bus.data_out     = '0;
      bus.cache_enable = '0;
      bus.cache_offset = '0;
      bus.mem_offset   = '0;
      bus.comp         = 1'b0;
      bus.write        = 1'b0;
      bus.tag_src      = 1'b0;
      bus.data_src     = 1'b0;
      bus.rd_out       = 1'b0;
      bus.wr_out       = 1'b0;
      bus.done         = 1'b0;
      bus.stall        = 1'b0;
      bus.hit          = 1'b0;
      bus.err          = 1'b0;
    end
  end
endmodule

// File: doc/cache_controller_nway.md
# cache_controller_nway

Parametrised successor to the two-way cache controller: drives an N-way set-associative, write-back, write-allocate cache built from per-way cache banks and a fixed-latency pipelined four-bank main memory. It sits between the processor memory port and the cache/memory arrays. It handles hits in one cycle. On a miss it evicts a dirty victim and refills the line with overlapped memory requests. It keeps per-set tree pseudo-LRU state internally.

## Interface
- WAYS, 2 — number of ways; 2 or 4
- WORDS_PER_LINE, 4 — 16-bit words per line; 4 or 8
- MEM_LAT, 2 — cycles from a memory read request to its data; 1..4
- INDEX_BITS, 8 — set index width
- OFF_W (derived) = log2(WORDS_PER_LINE)+1 — byte offset width; index is addr[OFF_W+INDEX_BITS-1:OFF_W]

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- addr_in  in  16  processor byte address
- data_in  in  16  processor write data
- rd_in, wr_in  in  1  processor request strobes
- cache_hit, cache_valid, cache_dirty  in  WAYS  per-way lookup results
- addr_out, data_out  out  16  address/data to arrays: live inputs in IDLE, latched request otherwise
- cache_enable  out  WAYS  way enables; all ways on lookup, one-hot victim otherwise
- cache_offset, mem_offset  out  OFF_W  word offset to cache / memory
- comp, write, tag_src, data_src  out  1  cache compare, cache write, tag select (1 = victim tag), data select (1 = memory data)
- rd_out, wr_out  out  1  memory read/write strobes
- done, stall, hit, err  out  1  processor status

## Operation
- States: IDLE, ALLOC, WB, FILL, DONE. Any other encoding sets err for one cycle and goes to IDLE.
- IDLE: comp=1, write=wr_in, cache_enable=all ones when rd_in|wr_in.
  - Hit is any way with hit&valid. On a hit: done=hit=1, PLRU updated, remain IDLE.
  - On a miss: stall=1; address, data, rd and wr are latched; go to ALLOC.
  - rd_in&wr_in: err=done=1, no array access, remain IDLE.
- ALLOC: victim is the lowest-index invalid way. If no way is invalid, the PLRU victim is used. The victim is held one-hot on cache_enable until DONE. If it is valid and dirty, go to WB, else FILL.
- WB: WORDS_PER_LINE cycles. comp=0, write=0, tag_src=1, wr_out=1. Word k is read from the cache and written to memory at offset 2k in cycle k.
- FILL: WORDS_PER_LINE+MEM_LAT cycles.
  - rd_out=1 with mem_offset=2k in cycle k, for k < WORDS_PER_LINE.
  - From cycle MEM_LAT: comp=0, write=1, data_src=1. Word j is written into the cache at offset 2j in cycle MEM_LAT+j.
- DONE: one cycle. comp=1, data_src=0, write=latched wr (merges the store), done=1, stall=0. PLRU marks the victim most-recent. Go to IDLE.
- PLRU: WAYS-1 bits per set, 2^INDEX_BITS sets, all zero on reset. Access to a way points the tree bits away from it. For WAYS=2 this is true LRU.
- Processor inputs are ignored outside IDLE. stall=1 in every state except IDLE and DONE.

## Timing
- Reset (rst low, asynchronous): state IDLE; every output 0; PLRU cleared; latched registers 0. Reset mid-miss abandons the line fill; the partially filled way is left to the cache's own reset.
- Hit latency: done in the request cycle.
- Clean miss: done = 2+WORDS_PER_LINE+MEM_LAT cycles after the request cycle (8 for defaults).
- Dirty miss: add WORDS_PER_LINE (12 for defaults).
- Memory requests are issued one per cycle, back to back. The controller never stalls on memory.

## Test plan
- Reset, then rd_in=1 on an empty cache, addr 0x0010 -> stall in cycle 0; enable=01; rd_out in cycles 2-5 at offsets 0,2,4,6; done at cycle 8; hit=0.
- Repeat the read of 0x0010 -> done=hit=1 in the same cycle; state stays IDLE.
- WAYS=2: fill 0x0010 and 0x1010 (same set), reread 0x0010, then write 0x2010 -> way 1 (LRU) is evicted. If dirty: wr_out in cycles 2-5, done at cycle 12.
- WAYS=4, WORDS_PER_LINE=8, MEM_LAT=3 clean miss -> done 13 cycles after the request; cache writes at offsets 0..14.
- rd_in=wr_in=1 -> err=done=1 for one cycle; no enable; no memory strobe.
- Assert rst low in the middle of FILL -> all outputs 0 immediately; the next request is handled as a fresh miss.
